// File: rtl/uart_frame_tx_ctrl_pkg.sv
// Shared types and constants for the UART frame transmit controller.
package uart_frame_tx_ctrl_pkg;

   // Frame sequencing states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Level driven on the serial line for the stop bit and while idle
   localparam logic STOP_LEVEL = 1'b1;

endpackage : uart_frame_tx_ctrl_pkg

// File: rtl/uart_frame_tx_ctrl_up_counter.sv
// Bit-index up counter: synchronous clear has priority over enable.
module uart_frame_tx_ctrl_up_counter #(
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] count_r;

   // Count register: clear wins, otherwise increment when enabled
   always_ff @(posedge clk) begin
      if (clr) begin
         count_r <= {CNT_WIDTH{1'b0}};
      end else if (en) begin
         count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule : uart_frame_tx_ctrl_up_counter

// File: rtl/uart_frame_tx_ctrl.sv
// Serial frame transmitter: start bit, WORD data bits LSB-first, optional
// parity, stop bit. Downstream ready=0 freezes all frame progress.
module uart_frame_tx_ctrl
   import uart_frame_tx_ctrl_pkg::*;
#(
   parameter int WORD       = 8,
   parameter int CNT_WIDTH  = 4,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD-1:0]      din,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic                 ready,
   output logic                 out,
   output logic                 done,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] bit_idx
);

   // Parity of the captured word, optionally inverted for odd parity
   function automatic logic calc_parity(input logic [WORD-1:0] w);
      return (^w) ^ (PARITY_ODD != 0);
   endfunction

   state_t          state_r, state_nxt_s;
   logic [WORD-1:0] shift_r, shift_nxt_s;
   logic            out_r, out_nxt_s;
   logic            done_r, done_nxt_s;
   logic            parity_r, parity_nxt_s;
   logic            din_ready_s, xfer_s, last_bit_s;
   logic            cnt_en_s, cnt_clr_s;
   logic [CNT_WIDTH-1:0] bit_idx_s;

   assign din_ready_s = (state_r == ST_IDLE) || ((state_r == ST_STOP) && ready);
   assign xfer_s      = din_valid && din_ready_s;
   assign last_bit_s  = (bit_idx_s == CNT_WIDTH'(WORD-1));
   assign cnt_en_s    = (state_r == ST_DATA) && ready && !last_bit_s;
   assign cnt_clr_s   = rst || ((state_r == ST_START) && ready);

   uart_frame_tx_ctrl_up_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bit_cnt (
      .clk   (clk),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .count (bit_idx_s)
   );

   // State and output registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         shift_r  <= {WORD{1'b0}};
         out_r    <= STOP_LEVEL;
         done_r   <= 1'b0;
         parity_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         shift_r  <= shift_nxt_s;
         out_r    <= out_nxt_s;
         done_r   <= done_nxt_s;
         parity_r <= parity_nxt_s;
      end
   end

   // Next-state logic; every non-idle state waits on ready
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) state_nxt_s = ST_START;
            else        state_nxt_s = ST_IDLE;
         end
         ST_START: begin
            if (ready) state_nxt_s = ST_DATA;
            else       state_nxt_s = ST_START;
         end
         ST_DATA: begin
            if (ready && last_bit_s) state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else                     state_nxt_s = ST_DATA;
         end
         ST_PARITY: begin
            if (ready) state_nxt_s = ST_STOP;
            else       state_nxt_s = ST_PARITY;
         end
         ST_STOP: begin
            if (ready && xfer_s) state_nxt_s = ST_START;
            else if (ready)      state_nxt_s = ST_IDLE;
            else                 state_nxt_s = ST_STOP;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath and registered-output values derived from the upcoming state
   always_comb begin
      shift_nxt_s  = shift_r;
      parity_nxt_s = parity_r;
      if (xfer_s) begin
         shift_nxt_s  = din;
         parity_nxt_s = calc_parity(din);
      end else if (cnt_en_s) begin
         shift_nxt_s  = {1'b0, shift_r[WORD-1:1]};
      end else begin
         shift_nxt_s  = shift_r;
      end

      done_nxt_s = (state_r == ST_STOP) && ready;

      case (state_nxt_s)
         ST_START:  out_nxt_s = 1'b0;
         ST_DATA:   out_nxt_s = shift_nxt_s[0];
         ST_PARITY: out_nxt_s = parity_nxt_s;
         ST_STOP:   out_nxt_s = STOP_LEVEL;
         ST_IDLE:   out_nxt_s = STOP_LEVEL;
         default:   out_nxt_s = STOP_LEVEL;
      endcase
   end

   assign din_ready = din_ready_s;
   assign out       = out_r;
   assign done      = done_r;
   assign busy      = (state_r != ST_IDLE);
   assign bit_idx   = bit_idx_s;

endmodule : uart_frame_tx_ctrl

// File: doc/uart_frame_tx_ctrl.md
Name: uart_frame_tx_ctrl

Overview:
Sequences the up_counter as the bit index for a serial frame transmitter. Accepts a parallel word over a valid/ready handshake and emits an asynchronous-style frame on a single serial output: start bit, WORD data bits LSB-first, optional parity, stop bit. Serial progress stalls whenever the downstream `ready` is low. Sits between the parallel word source (din) and the serial line (out), replacing ad-hoc counter control.

Parameters:
WORD, 8, data bits per frame.
CNT_WIDTH, 4, bit-index counter width; must satisfy 2**CNT_WIDTH >= WORD.
PARITY_EN, 1, 1 inserts a parity bit; 0 skips the PARITY state.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
din  input  WORD  parallel word to send.
din_valid  input  1  din is valid.
din_ready  output  1  block can accept din this cycle.
ready  input  1  downstream accepts serial progress this cycle; 0 stalls the frame.
out  output  1  serial line; idles at 1.
done  output  1  one-cycle pulse on frame completion.
busy  output  1  a frame is in progress (state != IDLE).
bit_idx  output  CNT_WIDTH  current data bit index (counter value).

Behaviour:
- Reset: one clock, synchronous and active-high. While rst is sampled high: state=IDLE, out=1, done=0, shift register=0, counter cleared. rst overrides all other inputs, including mid-frame: the frame is aborted and no done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- din_ready is combinational: (state==IDLE) || (state==STOP && ready). A transfer occurs on a rising edge where din_valid && din_ready. din is captured into the shift register at that edge.
- Transitions:
  - IDLE -> START on transfer.
  - START -> DATA when ready. The counter is cleared at this edge.
  - DATA -> PARITY (or STOP if PARITY_EN=0) when ready && bit_idx==WORD-1. Otherwise DATA holds; the counter increments and the shift register shifts right when ready.
  - PARITY -> STOP when ready.
  - STOP -> START if ready && transfer (back-to-back). STOP -> IDLE if ready && no transfer.
- Stall: ready=0 in any state other than IDLE freezes state, out, shift register and counter. In STOP with ready=0, din_ready=0.
- out is registered:
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: XOR of the captured word, XOR PARITY_ODD.
  - STOP: 1.
  - IDLE: 1.
- Parity is computed from the word as captured, not from the shifting register.
- Latency, transfer at edge k, no stalls:
  - start bit visible after edge k.
  - data bit i visible after edge k+1+i.
  - parity visible after edge k+1+WORD.
  - stop bit visible after edge k+2+WORD.
  - done=1 for exactly the cycle after edge k+3+WORD (the edge leaving STOP).
- Frame period: WORD+3 cycles with parity, WORD+2 without. Back-to-back transfers produce no idle gap.
- din_valid and din changes while busy and not in STOP are ignored. The in-flight frame is unaffected.
- bit_idx wraps only via the clear at START->DATA. It is never allowed to exceed WORD-1 in DATA.

Decomposition:
- Shared package: the state enum (IDLE/START/DATA/PARITY/STOP) and the localparam for the STOP idle level (1).
- One sub-module: the existing up_counter #(CNT_WIDTH) as the bit index.
  - en = (state==DATA) && ready && bit_idx != WORD-1.
  - clr = rst || (state==START && ready).

Test Plan:
- Basic frame: din=0xA5, WORD=8, even parity, ready=1, transfer at edge k -> out sequence 0,1,0,1,0,0,1,0,1,0,1 over cycles k..k+10; done high only after edge k+11; din_ready high again in the STOP cycle.
- Stall: din=0xA5; hold ready=0 for 5 cycles while data bit 3 is on out -> bit 3 (0) persists 6 cycles, bit_idx holds at 3, done delayed by exactly 5 cycles, no other bit changes.
- Back-to-back: 0xFF then 0x00 with din_valid held -> second start bit immediately follows the first stop bit, no idle cycle. Parity is 0 for both frames. done pulses are spaced 11 cycles apart.
- Odd parity, PARITY_ODD=1: din=0x55 -> parity bit=1. PARITY_EN=0: din=0x55 -> 10-cycle frame; done after edge k+10.
- Reset mid-frame: assert rst for 1 cycle while data bit 4 is on out -> next cycle out=1, busy=0, done=0, bit_idx=0, din_ready=1; no done pulse for the aborted frame.
- Ignore while busy: change din to 0x0F mid-frame with din_valid=1 -> current frame bits unchanged; 0x0F is accepted only in STOP and sent as the next frame.
